acc_cpu_sequencer: RTL

- Fetch/decode/execute controller for the 32x8 single-port program/data RAM.
- Drives the RAM address, write enable, write data and preload strobe.
- Consumes the RAM's registered read data.
- Holds PC, IR, accumulator and carry for a one-accumulator, 8-bit instruction set.

---
 rtl/acc_cpu_sequencer_pkg.sv | 16 +
 rtl/acc_cpu_sequencer_alu.sv | 20 ++
 rtl/acc_cpu_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/acc_cpu_sequencer_pkg.sv
// acc_cpu_sequencer_pkg: shared opcodes, state encoding and width defaults for the accumulator CPU sequencer.
package acc_cpu_sequencer_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_JN    = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;
  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_FETCH, S_DECODE, S_MEM_RD, S_EXEC, S_HALT
  } state_t;
endpackage

// File: rtl/acc_cpu_sequencer_alu.sv
// acc_cpu_sequencer_alu: combinational ADD/SUB with carry/borrow, plus zero/negative flags of the accumulator.
module acc_cpu_sequencer_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o,
  output logic         carry_o,
  output logic         zero_o,
  output logic         neg_o
);
  logic [W:0] r;
  // Bit W of the widened difference is the borrow (set when a < b).
  assign r       = sub_i ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, a_i} + {1'b0, b_i};
  assign y_o     = r[W-1:0];
  assign carry_o = r[W];
  assign zero_o  = a_i == '0;
  assign neg_o   = a_i[W-1];
endmodule

// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: fetch/decode/execute controller for a one-accumulator CPU on a 32x8 single-port RAM.
module acc_cpu_sequencer
  import acc_cpu_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit PRELOAD = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              ram_test_start,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              halted,
  output logic              busy
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c, alu_z, alu_n;
  assign opcode  = ir_q[DATA_W-1 -: 3];
  assign operand = ir_q[ADDR_W-1:0];
  acc_cpu_sequencer_alu #(.W(DATA_W)) u_alu (
    .a_i    (acc_q),
    .b_i    (ram_data_out),
    .sub_i  (opcode == OP_SUB),
    .y_o    (alu_y),
    .carry_o(alu_c),
    .zero_o (alu_z),
    .neg_o  (alu_n)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    acc_d          = acc_q;
    carry_d        = carry_q;
    ram_address    = pc_q;
    ram_we         = 1'b0;
    ram_test_start = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = PRELOAD ? S_PRELOAD : S_FETCH;
        pc_d    = '0;
      end
      S_PRELOAD: begin
        ram_test_start = 1'b1;
        state_d        = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = ram_data_out;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ram_data_out[DATA_W-1 -: 3] == OP_HALT ? S_HALT :
                  ram_data_out[DATA_W-1 -: 3] inside {OP_LOAD, OP_ADD, OP_SUB} ? S_MEM_RD : S_EXEC;
      end
      S_MEM_RD: begin
        ram_address = operand;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        ram_address = operand;
        state_d     = S_FETCH;
        case (opcode)
          OP_LOAD:  acc_d = ram_data_out;
          OP_STORE: ram_we = 1'b1;
          OP_ADD, OP_SUB: begin
            acc_d   = alu_y;
            carry_d = alu_c;
          end
          OP_JMP:  pc_d = operand;
          OP_JZ:   pc_d = alu_z ? operand : pc_q;
          OP_JN:   pc_d = alu_n ? operand : pc_q;
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end
  assign ram_data_in = acc_q;
  assign acc         = acc_q;
  assign pc          = pc_q;
  assign carry       = carry_q;
  assign halted      = state_q == S_HALT;
  assign busy        = !(state_q inside {S_IDLE, S_HALT});
endmodule
